// File: rtl/universal_shift_register.sv
// Parametrised shift register: parallel load, then AMT single-bit steps (logical/arith/rotate/serial).
// Latency: LOAD takes 1 cycle; a START of N>0 steps is busy for N cycles, then DONE pulses; N==0 gives DONE next cycle.
// Backpressure: LOAD/START are only sampled in IDLE; while BUSY they are ignored and never queued.
module universal_shift_register #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 4
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] DIN,
    input  logic             START,
    input  logic             DIR,
    input  logic [1:0]       OP,
    input  logic [AMT_W-1:0] AMT,
    input  logic             SIN,
    output logic [WIDTH-1:0] Q,
    output logic             SOUT,
    output logic             BUSY,
    output logic             DONE
);

    typedef enum logic {ST_IDLE, ST_SHIFT} state_t;

    typedef enum logic [1:0] {
        OP_LOGIC = 2'b00,
        OP_ARITH = 2'b01,
        OP_ROT   = 2'b10,
        OP_SER   = 2'b11
    } op_t;

    typedef struct packed {
        logic dir;
        op_t  op;
    } cmd_t;

    state_t           state;
    cmd_t             cmd_q;
    logic [AMT_W-1:0] cnt;

    logic             fill;
    logic [WIDTH-1:0] step_q;
    logic             step_sout;

    // One step of the latched command; SIN is deliberately read live, not latched.
    always_comb begin
        fill      = 1'b0;
        step_q    = Q;
        step_sout = SOUT;
        if (!cmd_q.dir) begin
            case (cmd_q.op)
                OP_ROT:  fill = Q[WIDTH-1];
                OP_SER:  fill = SIN;
                default: fill = 1'b0;
            endcase
            step_q    = {Q[WIDTH-2:0], fill};
            step_sout = Q[WIDTH-1];
        end else begin
            case (cmd_q.op)
                OP_ARITH: fill = Q[WIDTH-1];
                OP_ROT:   fill = Q[0];
                OP_SER:   fill = SIN;
                default:  fill = 1'b0;
            endcase
            step_q    = {fill, Q[WIDTH-1:1]};
            step_sout = Q[0];
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state <= ST_IDLE;
            cmd_q <= '0;
            cnt   <= '0;
            Q     <= '0;
            SOUT  <= 1'b0;
            BUSY  <= 1'b0;
            DONE  <= 1'b0;
        end else begin
            DONE <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (LOAD) begin
                        Q <= DIN;
                    end else if (START) begin
                        if (AMT != '0) begin
                            cmd_q <= '{dir: DIR, op: op_t'(OP)};
                            cnt   <= AMT;
                            BUSY  <= 1'b1;
                            state <= ST_SHIFT;
                        end else begin
                            DONE <= 1'b1;
                        end
                    end
                end
                ST_SHIFT: begin
                    Q    <= step_q;
                    SOUT <= step_sout;
                    cnt  <= cnt - 1'b1;
                    // Last step: returning to IDLE here lets a new command land in the DONE cycle.
                    if (cnt == AMT_W'(1)) begin
                        BUSY  <= 1'b0;
                        DONE  <= 1'b1;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
